// File: rtl/tcp_tx_framer.sv
// rtl/tcp_tx_framer.sv - Ethernet II + IPv4 + TCP frame builder, one byte per cycle
//
// Ports:
//   CLOCK, RESET            clock (posedge) and asynchronous active-high reset
//   start                   frame request, only looked at while idle
//   payload_len, tcp_flags, seq_init, ack_num,
//   dst_mac, dst_ip, dst_port   request fields, captured when start is taken
//   in_data, in_valid       payload byte stream in
//   in_ready                payload byte accepted this cycle when in_valid is high
//   busy                    a frame is in progress
//   newpkt                  one-cycle start-of-frame marker (no data with it)
//   dataValid, data         outgoing frame bytes
//   done                    one-cycle pulse after the last frame byte
//   next_seq                running TCP send sequence number
module tcp_tx_framer #(
    parameter logic [47:0] mac  = 48'h000000000000,
    parameter logic [31:0] ip   = 32'h11223344,
    parameter logic [15:0] port = 16'd80,
    parameter logic [7:0]  ttl  = 8'd64,
    parameter logic [15:0] win  = 16'hFFFF
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  logic [7:0]  tcp_flags,
    input  logic [31:0] seq_init,
    input  logic [31:0] ack_num,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] dst_port,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        newpkt,
    output logic        dataValid,
    output logic [7:0]  data,
    output logic        done,
    output logic [31:0] next_seq
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_SOF, S_HDR, S_PAY, S_FIN} state_t;

    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  flags;
        logic [31:0] seq_tx;
        logic [31:0] ack;
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [15:0] dport;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [15:0] cnt_q, cnt_d;        // CALC word index, HDR byte index, PAY bytes left
    logic [19:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] ipid_q, ipid_d;
    logic [31:0] seq_q, seq_d;
    logic        busy_q, busy_d;
    logic        newpkt_q, newpkt_d;
    logic        dv_q, dv_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        in_ready_q, in_ready_d;

    logic [15:0]  total_len;
    logic [15:0]  calc_word;
    logic [16:0]  fold1;
    logic [15:0]  fold2;
    logic [431:0] hdr_vec;
    logic [8:0]   hdr_pos;
    logic [7:0]   hdr_byte;

    assign total_len = 16'd40 + req_q.len;

    always_comb begin
        calc_word = 16'h0000;
        case (cnt_q[3:0])
            4'd0:    calc_word = 16'h4500;
            4'd1:    calc_word = total_len;
            4'd2:    calc_word = ipid_q;
            4'd3:    calc_word = 16'h4000;
            4'd4:    calc_word = {ttl, 8'h06};
            4'd5:    calc_word = ip[31:16];
            4'd6:    calc_word = ip[15:0];
            4'd7:    calc_word = req_q.dip[31:16];
            4'd8:    calc_word = req_q.dip[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    // Two end-around folds are enough: nine words keep the sum below 2^20.
    assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
    assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

    // Whole 54-byte header as one vector, first byte in the top bits.
    assign hdr_vec = {req_q.dmac, mac, 16'h0800,
                      16'h4500, total_len, ipid_q, 16'h4000, ttl, 8'h06, csum_q, ip, req_q.dip,
                      port, req_q.dport, req_q.seq_tx, req_q.ack, 8'h50, req_q.flags, win, 32'h0};
    assign hdr_pos  = 9'd431 - {cnt_q[5:0], 3'b000};
    assign hdr_byte = hdr_vec[hdr_pos -: 8];

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        csum_d     = csum_q;
        ipid_d     = ipid_q;
        seq_d      = seq_q;
        busy_d     = busy_q;
        newpkt_d   = 1'b0;
        dv_d       = 1'b0;
        data_d     = 8'h00;
        done_d     = 1'b0;
        in_ready_d = in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    req_d.len    = payload_len;
                    req_d.flags  = tcp_flags;
                    req_d.seq_tx = tcp_flags[1] ? seq_init : seq_q;
                    req_d.ack    = ack_num;
                    req_d.dmac   = dst_mac;
                    req_d.dip    = dst_ip;
                    req_d.dport  = dst_port;
                    busy_d       = 1'b1;
                    cnt_d        = 16'd0;
                    acc_d        = 20'd0;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == 16'd9) begin
                    csum_d  = ~fold2;
                    state_d = S_SOF;
                end else begin
                    acc_d = acc_q + {4'd0, calc_word};
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SOF: begin
                newpkt_d = 1'b1;
                cnt_d    = 16'd0;
                state_d  = S_HDR;
            end
            S_HDR: begin
                dv_d   = 1'b1;
                data_d = hdr_byte;
                if (cnt_q == 16'd53) begin
                    if (req_q.len == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d      = req_q.len;
                        in_ready_d = 1'b1;
                        state_d    = S_PAY;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_PAY: begin
                if (in_valid) begin
                    dv_d   = 1'b1;
                    data_d = in_data;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        in_ready_d = 1'b0;
                        state_d    = S_FIN;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ipid_d  = ipid_q + 16'd1;
                seq_d   = req_q.seq_tx + {16'd0, req_q.len}
                          + {31'd0, req_q.flags[1]} + {31'd0, req_q.flags[0]};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            cnt_q      <= 16'd0;
            acc_q      <= 20'd0;
            csum_q     <= 16'd0;
            ipid_q     <= 16'd0;
            seq_q      <= 32'd0;
            busy_q     <= 1'b0;
            newpkt_q   <= 1'b0;
            dv_q       <= 1'b0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            csum_q     <= csum_d;
            ipid_q     <= ipid_d;
            seq_q      <= seq_d;
            busy_q     <= busy_d;
            newpkt_q   <= newpkt_d;
            dv_q       <= dv_d;
            data_q     <= data_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign newpkt    = newpkt_q;
    assign dataValid = dv_q;
    assign data      = data_q;
    assign done      = done_q;
    assign next_seq  = seq_q;

endmodule
